// File: rtl/fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
// No logic; constants only.
// Defaults are overridden per instance through the WIDTH/DEPTH parameters.
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage

// File: rtl/fifo_mem.sv
// Storage array with one synchronous write port and one registered read port.
// Latency: write visible to a read on the following edge; read data one cycle after rd_en.
// Backpressure: none here; the caller only enables ports for accepted transfers.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Array contents are deliberately left unreset; pointers make stale words unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port; holds its value whenever no read is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_enipe_guard(rd_en)) begin
      rd_data <= mem[rd_addr];
    end
  end

  function automatic logic rd_enipe_guard(input logic en);
    return en;
  endfunction

endmodule

// File: rtl/fifo_sim.sv
// Single-clock FIFO: pointer, occupancy and flag control around fifo_mem.
// Latency: data_out valid one cycle after the edge that accepts a read.
// Backpressure: writes dropped while full, reads ignored while empty; flags decode the live count.
module fifo_sim
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             wr,
  input  logic             rd,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [31:0]      data_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_acc;
  logic          rd_acc;

  // Acceptance qualifies requests with the flags, so a full FIFO still reads and an empty one still writes.
  assign wr_acc = wr && !full;
  assign rd_acc = rd && !empty;

  // Flags are pure decodes of the registered count: no extra latency.
  assign empty      = (count == '0);
  assign full       = (count == CNT_DEPTH);
  assign data_count = {{(32-AW-1){1'b0}}, count};

  // Pointers advance on accepted transfers; power-of-two depth makes wrap a natural rollover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Occupancy: a simultaneous accepted read and write cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr),
    .rd_data (data_out)
  );

endmodule

// File: tb/tb_fifo_sim.sv
// Bench for fifo_sim: directed scenarios plus randomized traffic against a queue model.
// The compare process checks every negative edge once the first reset has been applied.
// Directed steps also carry hand-computed literal expectations.
module tb_fifo_sim;
  import fifo_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  word_t       data_in = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  word_t       data_out;
  logic        empty;
  logic        full;
  logic [31:0] data_count;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Reference model: a plain queue and the last word read out.
  word_t model_q[$];
  word_t model_dout = '0;

  fifo_sim #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .wr         (wr),
    .rd         (rd),
    .data_out   (data_out),
    .empty      (empty),
    .full       (full),
    .data_count (data_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the specification's rules: reset clears, otherwise read-then-write on the pre-edge contents.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      automatic bit racc = rd && (model_q.size() > 0);
      automatic bit wacc = wr && (model_q.size() < DEPTH);
      if (racc) model_dout = model_q.pop_front();
      if (wacc) model_q.push_back(data_in);
    end
  end

  // Continuous comparison, half a cycle away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mdl_data_out", 32'(data_out), 32'(model_dout));
      chk("mdl_count", data_count, 32'(model_q.size()));
      chk("mdl_empty", 32'(empty), 32'(model_q.size() == 0));
      chk("mdl_full", 32'(full), 32'(model_q.size() == DEPTH));
    end
  end

  // One clock of stimulus; inputs change 1 time unit after the active edge.
  task automatic step(input logic w, input logic r, input word_t d);
    wr = w;
    rd = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Reset check
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_count", data_count, 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);

    // Write 10 x 0xAA then hold rd for 50 cycles
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 8'hAA);
      chk("wd_count", data_count, 32'(i));
      chk("wd_empty", 32'(empty), 32'd0);
    end
    for (int k = 0; k < 50; k++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("wd_dout", 32'(data_out), 32'hAA);
      chk("wd_drain_count", data_count, (k < 10) ? 32'(9 - k) : 32'd0);
    end
    chk("wd_final_empty", 32'(empty), 32'd1);

    // Ordering across pointer wrap
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, word_t'(i));
    chk("ord_full", 32'(full), 32'd1);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("ord_dout", 32'(data_out), 32'(i));
    end
    for (int i = 16; i < 26; i++) step(1'b1, 1'b0, word_t'(i));
    for (int i = 16; i < 26; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("wrap_dout", 32'(data_out), 32'(i));
    end

    // Overflow: 20 writes into an empty FIFO
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, word_t'(8'h30 + i));
      if (i == 15) begin
        chk("ovf_full16", 32'(full), 32'd1);
        chk("ovf_count16", data_count, 32'd16);
      end
    end
    chk("ovf_count20", data_count, 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("ovf_dout", 32'(data_out), 32'(8'h30 + i));
    end
    step(1'b0, 1'b1, 8'h00);
    chk("ovf_extra_dout", 32'(data_out), 32'h3F);
    chk("ovf_empty", 32'(empty), 32'd1);

    // Simultaneous access at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, word_t'(8'h50 + i));
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, word_t'(8'h60 + k));
      chk("sim_count", data_count, 32'd5);
      chk("sim_dout", 32'(data_out), (k < 5) ? 32'(8'h50 + k) : 32'(8'h60 + k - 5));
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 8'h00);
      chk("sim_drain", 32'(data_out), 32'(8'h63 + k));
    end
    step(1'b1, 1'b1, 8'h70);
    chk("sim_at_empty", data_count, 32'd1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, word_t'(8'h71 + i));
    chk("sim_pre_full", 32'(full), 32'd1);
    step(1'b1, 1'b1, 8'hEE);
    chk("sim_at_full", data_count, 32'd15);
    chk("sim_at_full_dout", 32'(data_out), 32'h70);
    pulse_reset();

    // Mid-operation reset between edges
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, word_t'(8'h90 + i));
    chk("mid_pre_count", data_count, 32'd7);
    #2;
    rst = 1'b1;
    wr = 1'b1;
    rd = 1'b1;
    #1;
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_count", data_count, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_hold_count", data_count, 32'd0);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'h77);
    chk("mid_new_count", data_count, 32'd1);
    step(1'b0, 1'b1, 8'h00);
    chk("mid_new_dout", 32'(data_out), 32'h77);
    chk("mid_new_empty", 32'(empty), 32'd1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        automatic int mode = $urandom_range(0, 2);
        automatic logic w = (mode == 0) ? ($urandom_range(0, 3) != 0) : (mode == 1) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1);
        automatic logic r = (mode == 1) ? ($urandom_range(0, 3) != 0) : (mode == 0) ? ($urandom_range(0, 3) == 0) : $urandom_range(0, 1);
        step(w, r, word_t'($urandom));
      end
    end

    wr = 1'b0;
    rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sim.md
FIFO_SIM -- requirements
Module: fifo_sim

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 16, number of storage entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 data_in  input  WIDTH  write data, sampled when a write is accepted.
REQ-006 wr  input  1  write request, level-sensitive, one word per clk cycle while high.
REQ-007 rd  input  1  read request, level-sensitive, one word per clk cycle while high.
REQ-008 data_out  output  WIDTH  registered read data.
REQ-009 empty  output  1  high when stored word count is 0.
REQ-010 full  output  1  high when stored word count equals DEPTH.
REQ-011 data_count  output  32  number of words currently stored, zero-extended.

Function
REQ-012 The block SHALL be a synchronous single-clock first-in-first-out buffer; words SHALL be read out in write order.
REQ-013 A write SHALL be accepted on a rising edge when wr=1 and full=0.
- The accepted data_in word is stored at the write pointer.
- The write pointer then advances by 1 modulo DEPTH.
REQ-014 A write while full=1 SHALL be ignored: no storage change, no pointer change, no count change.
REQ-015 A read SHALL be accepted on a rising edge when rd=1 and empty=0.
- data_out is loaded with the word at the read pointer.
- The read pointer then advances by 1 modulo DEPTH.
REQ-016 Read latency SHALL be one cycle: the word is valid on data_out after the accepting edge.
REQ-017 A read while empty=1 SHALL be ignored; data_out SHALL hold its previous value.
REQ-018 data_out SHALL hold its value in every cycle without an accepted read.
REQ-019 data_count SHALL update on each edge as follows:
- +1 for an accepted write alone.
- -1 for an accepted read alone.
- Unchanged when both are accepted, or when neither is.
REQ-020 Simultaneous wr=1 and rd=1 cases:
- When 0 < count < DEPTH, both SHALL be accepted in the same cycle.
- When empty, only the write SHALL be accepted.
- When full, only the read SHALL be accepted.
REQ-021 empty and full SHALL be combinational decodes of the registered count. They change in the same cycle that data_count reaches 0 or DEPTH; there is no extra flag latency.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0 without a gap.
REQ-023 data_count SHALL never exceed DEPTH and SHALL never go below 0.

Reset
REQ-024 While rst=1, the following SHALL take and hold their reset values immediately, independent of clk:
- Read and write pointers = 0.
- data_count = 0, empty = 1, full = 0.
- data_out = 0.
REQ-025 Storage contents SHALL NOT be reset; stale words SHALL be unreachable after reset.
REQ-026 Reset asserted mid-operation SHALL discard all stored words; wr and rd SHALL be ignored while rst=1.
REQ-027 After rst deasserts, the first rising edge SHALL accept requests normally.

Structure
REQ-028 Package fifo_pkg SHALL hold the default WIDTH and DEPTH constants and a data word typedef. Pointer width SHALL be derived as $clog2(DEPTH).
REQ-029 One sub-module, fifo_mem, SHALL implement the storage array.
- Interface: one write port and one read port.
- Write is synchronous; read is registered.
REQ-030 fifo_sim SHALL contain pointer, count and flag logic, and SHALL instantiate fifo_mem.

Verification
REQ-031 Reset check: pulse rst for 1 cycle -> data_count=0, empty=1, full=0, data_out=0.
REQ-032 Write then drain, with DEPTH=16:
- Stimulus: write 10 words of 0xAA, then hold rd=1 for 50 cycles.
- Required: data_count rises 1..10, empty falls after the first write.
- Required: 10 reads return 0xAA, then count=0 and empty=1.
- Required: the remaining 40 reads are ignored, with data_out held at 0xAA.
REQ-033 Ordering and wrap:
- Stimulus: write 0x00..0x0F, read all, then write 0x10..0x19 and read all.
- Required: outputs appear in write order, including across the pointer wrap.
REQ-034 Overflow:
- Stimulus: write 20 distinct words into an empty FIFO.
- Required: full=1 and data_count=16 after the 16th write.
- Required: writes 17-20 are dropped, and reads return only the first 16 words.
REQ-035 Simultaneous access:
- Stimulus: at count 5, assert wr=1 and rd=1 for 8 cycles.
- Required: data_count stays 5 and output order is preserved.
- Stimulus: at count 0 or 16, assert wr=1 and rd=1 for 1 cycle.
- Required: count becomes 1 or 15 respectively.
REQ-036 Mid-operation reset:
- Stimulus: write 7 words, then assert rst between clock edges.
- Required: empty=1 and data_count=0 immediately.
- Required: a subsequent single write/read returns the new word.
